// File: rtl/fit_eval_arbiter.sv
// Round-robin arbiter sharing one multi-cycle fitness unit among NUM_REQ GA requesters.
// Optional watchdog on the FU response enabled by defining FIT_ARB_TIMEOUT_EN.
module fit_eval_arbiter #(
  parameter int unsigned NUM_REQ       = 4,
  parameter int unsigned CHROM_WIDTH   = 16,
  parameter int unsigned FITNESS_WIDTH = (CHROM_WIDTH + 1) * 3,
  parameter int unsigned TIMEOUT       = 64
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_REQ-1:0]             req_valid,
  output logic [NUM_REQ-1:0]             req_ready,
  input  logic [NUM_REQ*CHROM_WIDTH-1:0] req_chrom,
  output logic [NUM_REQ-1:0]             rsp_valid,
  input  logic [NUM_REQ-1:0]             rsp_ready,
  output logic [FITNESS_WIDTH-1:0]       rsp_fit,
  output logic                           fu_start,
  output logic [CHROM_WIDTH-1:0]         fu_chrom,
  input  logic                           fu_done,
  input  logic [FITNESS_WIDTH-1:0]       fu_fit,
  output logic                           busy,
  output logic [15:0]                    eval_count,
  output logic                           timeout_err
);

  localparam int unsigned GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t            state_q, state_d;
  logic [GW-1:0]     grant_q, grant_d;
  logic [GW-1:0]     last_q, last_d;
  logic [GW-1:0]     sel, idx;
  logic              sel_vld;
  logic              ld_fit;
  logic              tmo_hit;
  logic [CHROM_WIDTH-1:0] chrom_arr [NUM_REQ];

  function automatic logic [NUM_REQ-1:0] onehot(input logic [GW-1:0] i);
    logic [NUM_REQ-1:0] v;
    v    = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_chrom
    assign chrom_arr[i] = req_chrom[i*CHROM_WIDTH +: CHROM_WIDTH];
  end

  // Round-robin search starting just after the last completed grant.
  always_comb begin
    sel     = '0;
    sel_vld = 1'b0;
    idx     = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      idx = GW'((32'(last_q) + k) % NUM_REQ);
      if (!sel_vld && req_valid[idx]) begin
        sel     = idx;
        sel_vld = 1'b1;
      end
    end
  end

  // Next-state and handshake decode.
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    last_d    = last_q;
    req_ready = '0;
    ld_fit    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (sel_vld) begin
          req_ready = onehot(sel);
          grant_d   = sel;
          state_d   = ISSUE;
        end
      end
      ISSUE: state_d = WAIT;
      WAIT: begin
        if (fu_done) begin
          ld_fit  = 1'b1;
          state_d = RESP;
        end else if (tmo_hit) begin
          state_d = RESP;
        end
      end
      RESP: begin
        if (rsp_ready[grant_q]) begin
          last_d  = grant_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      last_q     <= GW'(NUM_REQ - 1);
      fu_start   <= 1'b0;
      busy       <= 1'b0;
      rsp_valid  <= '0;
      fu_chrom   <= '0;
      rsp_fit    <= '0;
      eval_count <= '0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      last_q    <= last_d;
      fu_start  <= (state_d == ISSUE);
      busy      <= (state_d != IDLE);
      rsp_valid <= (state_d == RESP) ? onehot(grant_d) : '0;
      if (state_q == IDLE && sel_vld) begin
        fu_chrom <= chrom_arr[sel];
      end
      if (ld_fit) begin
        rsp_fit    <= fu_fit;
        eval_count <= eval_count + 16'd1;
      end else if (tmo_hit) begin
        rsp_fit <= '1;
      end
    end
  end

`ifdef FIT_ARB_TIMEOUT_EN
  localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [TW-1:0] tmo_cnt;

  assign tmo_hit = (state_q == WAIT) && !fu_done && (tmo_cnt == TW'(TIMEOUT - 1));

  // Watchdog counts WAIT cycles; a hit reports worst fitness and sets a sticky flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tmo_cnt     <= '0;
      timeout_err <= 1'b0;
    end else begin
      tmo_cnt <= (state_q == WAIT) ? tmo_cnt + TW'(1) : '0;
      if (tmo_hit) begin
        timeout_err <= 1'b1;
      end
    end
  end
`else
  logic unused_timeout;

  assign tmo_hit        = 1'b0;
  assign timeout_err    = 1'b0;
  assign unused_timeout = ^TIMEOUT;
`endif

endmodule

// File: tb/tb_fit_eval_arbiter.sv
// Self-checking bench for fit_eval_arbiter: vector table plus scoreboarded corner-case sequences.
module tb_fit_eval_arbiter;

  localparam int unsigned NR  = 4;
  localparam int unsigned CW  = 16;
  localparam int unsigned FW  = (CW + 1) * 3;
  localparam int unsigned TMO = 8;
  localparam int unsigned NV  = 14;

  logic             clk = 1'b0;
  logic             reset;
  logic [NR-1:0]    req_valid, req_ready, rsp_valid, rsp_ready;
  logic [NR*CW-1:0] req_chrom;
  logic [FW-1:0]    rsp_fit, fu_fit, spur_fit, ovr_fit;
  logic [FW-1:0]    fu_fit_m = '0;
  logic [FW-1:0]    fu_resp = '0;
  logic             fu_start, fu_done, fu_spur, busy, timeout_err;
  logic             fu_done_m = 1'b0;
  logic             fu_en, ovr_en;
  logic [CW-1:0]    fu_chrom;
  logic [15:0]      eval_count;
  int               fu_lat;
  int               fu_cnt = 0;

  logic [CW-1:0] lane [NR] = '{16'hA1EF, 16'h3C5A, 16'h7E81, 16'hF00D};

  typedef struct { logic [NR-1:0] valid; int grant; int lat; } vec_t;
  typedef struct { logic [NR-1:0] oh; logic [CW-1:0] chrom; } gexp_t;
  typedef struct { logic [NR-1:0] oh; logic [FW-1:0] fit; } rexp_t;

  vec_t  vecs [NV];
  gexp_t gq [$];
  rexp_t rq [$];

  int total = 0;
  int bad = 0;
  int rsp_cnt = 0;
  int exp_rsp = 0;
  int fs_cnt = 0;
  bit done = 1'b0;
  bit pend_vld = 1'b0;
  logic [CW-1:0] pend_chrom = '0;

  always #5 clk = ~clk;

  assign req_chrom = {lane[3], lane[2], lane[1], lane[0]};
  assign fu_done   = fu_done_m | fu_spur;
  assign fu_fit    = fu_spur ? spur_fit : fu_fit_m;

  fit_eval_arbiter #(
    .NUM_REQ(NR), .CHROM_WIDTH(CW), .FITNESS_WIDTH(FW), .TIMEOUT(TMO)
  ) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_chrom(req_chrom),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_fit(rsp_fit),
    .fu_start(fu_start), .fu_chrom(fu_chrom), .fu_done(fu_done), .fu_fit(fu_fit),
    .busy(busy), .eval_count(eval_count), .timeout_err(timeout_err)
  );

  function automatic logic [FW-1:0] fitfn(input logic [CW-1:0] c);
    return FW'({c, c ^ 16'h0F0F});
  endfunction

  // Fitness unit model: answers fu_lat cycles after the start pulse.
  always @(posedge clk) begin
    fu_done_m <= 1'b0;
    if (fu_cnt != 0) begin
      fu_cnt <= fu_cnt - 1;
      if (fu_cnt == 1) begin
        fu_done_m <= 1'b1;
        fu_fit_m  <= fu_resp;
      end
    end else if (fu_start && fu_en) begin
      fu_cnt  <= fu_lat;
      fu_resp <= ovr_en ? ovr_fit : fitfn(fu_chrom);
    end
  end

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", name, got, exp, $time);
    end
  endtask

  task automatic expect_txn(input int g, input logic [FW-1:0] fit, input bit with_rsp);
    gexp_t ge;
    rexp_t re;
    ge.oh    = 4'(1) << g;
    ge.chrom = lane[g];
    gq.push_back(ge);
    if (with_rsp) begin
      re.oh  = ge.oh;
      re.fit = fit;
      rq.push_back(re);
      exp_rsp++;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Returns one cycle after the transfer edge (DUT then in ISSUE).
  task automatic wait_accept();
    int n = 0;
    #1;
    while (req_ready == '0 && n < 100) begin
      step();
      n++;
    end
    chk("accept_seen", 64'(req_ready != '0), 64'd1);
    step();
  endtask

  task automatic wait_cnt(input int target);
    int n = 0;
    while (rsp_cnt < target && n < 400) begin
      step();
      n++;
    end
    chk("rsp_count", 64'(rsp_cnt), 64'(target));
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_req_ready"},  64'(req_ready),   64'd0);
    chk({tag, "_rsp_valid"},  64'(rsp_valid),   64'd0);
    chk({tag, "_rsp_fit"},    64'(rsp_fit),     64'd0);
    chk({tag, "_fu_start"},   64'(fu_start),    64'd0);
    chk({tag, "_fu_chrom"},   64'(fu_chrom),    64'd0);
    chk({tag, "_busy"},       64'(busy),        64'd0);
    chk({tag, "_eval_count"}, 64'(eval_count),  64'd0);
    chk({tag, "_timeout"},    64'(timeout_err), 64'd0);
  endtask

  task automatic monitor();
    gexp_t ge;
    rexp_t re;
    while (!done) begin
      @(negedge clk);
      if (!reset) begin
        if (req_ready != '0) begin
          chk("grant_expected", 64'(gq.size() != 0), 64'd1);
          if (gq.size() != 0) begin
            ge = gq.pop_front();
            chk("grant_onehot", 64'(req_ready), 64'(ge.oh));
            pend_vld   = 1'b1;
            pend_chrom = ge.chrom;
          end
        end
        if (fu_start) begin
          fs_cnt++;
          chk("fu_start_expected", 64'(pend_vld), 64'd1);
          if (pend_vld) chk("fu_chrom", 64'(fu_chrom), 64'(pend_chrom));
          pend_vld = 1'b0;
        end
        if ((rsp_valid & rsp_ready) != '0) begin
          rsp_cnt++;
          chk("rsp_expected", 64'(rq.size() != 0), 64'd1);
          if (rq.size() != 0) begin
            re = rq.pop_front();
            chk("rsp_valid", 64'(rsp_valid), 64'(re.oh));
            chk("rsp_fit", 64'(rsp_fit), 64'(re.fit));
          end
        end
      end
    end
  endtask

  task automatic stimulus();
    int n;
    logic [FW-1:0] ones;
    ones = '1;

    // Single request from reset with a fixed FU answer.
    repeat (2) @(posedge clk);
    #1;
    check_reset_vals("rst");
    reset = 1'b0;
    step();
    ovr_en  = 1'b1;
    ovr_fit = FW'(20'h00123);
    fu_lat  = 3;
    expect_txn(0, ovr_fit, 1'b1);
    req_valid = 4'b0001;
    wait_accept();
    req_valid = '0;
    wait_cnt(exp_rsp);
    chk("t1_eval_count", 64'(eval_count), 64'd1);
    chk("t1_fu_starts", 64'(fs_cnt), 64'd1);
    ovr_en = 1'b0;

    // Table of back-to-back requests from a fresh reset; valids held between grants.
    reset = 1'b1;
    repeat (2) step();
    reset = 1'b0;
    step();
    for (int i = 0; i < int'(NV); i++) begin
      fu_lat = vecs[i].lat;
      expect_txn(vecs[i].grant, fitfn(lane[vecs[i].grant]), 1'b1);
      req_valid = vecs[i].valid;
      wait_accept();
      if (i == int'(NV) - 1) req_valid = '0;
      wait_cnt(exp_rsp);
    end
    chk("tbl_eval_count", 64'(eval_count), 64'(NV));

    // Response back-pressure: outputs hold, no new grant or launch.
    rsp_ready = '0;
    fu_lat    = 2;
    expect_txn(1, fitfn(lane[1]), 1'b1);
    req_valid = 4'b0010;
    wait_accept();
    req_valid = '0;
    n = 0;
    while (rsp_valid == '0 && n < 100) begin
      step();
      n++;
    end
    req_valid = '1;
    expect_txn(2, fitfn(lane[2]), 1'b1);
    repeat (10) begin
      step();
      chk("hold_rsp_valid", 64'(rsp_valid), 64'(4'b0010));
      chk("hold_rsp_fit",   64'(rsp_fit),   64'(fitfn(lane[1])));
      chk("hold_req_ready", 64'(req_ready), 64'd0);
      chk("hold_fu_start",  64'(fu_start),  64'd0);
    end
    rsp_ready = '1;
    wait_cnt(exp_rsp - 1);
    step();
    req_valid = '0;
    wait_cnt(exp_rsp);

    // Reset during WAIT; the late FU answer must be dropped.
    fu_lat = 6;
    expect_txn(3, '0, 1'b0);
    req_valid = '1;
    wait_accept();
    req_valid = '0;
    repeat (2) step();
    reset = 1'b1;
    gq.delete();
    rq.delete();
    pend_vld = 1'b0;
    exp_rsp  = rsp_cnt;
    repeat (2) step();
    reset = 1'b0;
    repeat (8) step();
    check_reset_vals("mid_rst");
    fu_lat = 2;
    expect_txn(0, fitfn(lane[0]), 1'b1);
    req_valid = '1;
    wait_accept();
    req_valid = '0;
    wait_cnt(exp_rsp);
    chk("post_rst_eval", 64'(eval_count), 64'd1);

    // Spurious fu_done in IDLE and ISSUE.
    spur_fit = FW'(32'h777);
    fu_spur  = 1'b1;
    step();
    fu_spur = 1'b0;
    repeat (3) step();
    chk("spur_idle_eval", 64'(eval_count), 64'd1);
    chk("spur_idle_rsp",  64'(rsp_valid),  64'd0);
    chk("spur_idle_busy", 64'(busy),       64'd0);
    chk("spur_idle_fit",  64'(rsp_fit),    64'(fitfn(lane[0])));
    fu_lat = 4;
    expect_txn(3, fitfn(lane[3]), 1'b1);
    req_valid = 4'b1000;
    wait_accept();
    req_valid = '0;
    chk("issue_fu_start", 64'(fu_start), 64'd1);
    fu_spur = 1'b1;
    step();
    fu_spur = 1'b0;
    wait_cnt(exp_rsp);
    chk("spur_issue_eval", 64'(eval_count), 64'd2);

`ifdef FIT_ARB_TIMEOUT_EN
    // Silent FU: watchdog answers with worst fitness after TMO WAIT cycles.
    fu_en = 1'b0;
    expect_txn(1, ones, 1'b1);
    req_valid = 4'b0010;
    wait_accept();
    req_valid = '0;
    n = 0;
    while (rsp_valid == '0 && n < 50) begin
      step();
      n++;
    end
    chk("tmo_latency", 64'(n), 64'(TMO + 1));
    chk("tmo_err", 64'(timeout_err), 64'd1);
    chk("tmo_eval", 64'(eval_count), 64'd2);
    wait_cnt(exp_rsp);
    fu_en = 1'b1;
`else
    chk("tmo_err_tied", 64'(timeout_err), 64'd0);
    chk("all_ones_unused", 64'(rsp_fit == ones), 64'd0);
`endif
    repeat (3) step();
  endtask

  initial begin
    reset     = 1'b1;
    req_valid = '0;
    rsp_ready = '1;
    fu_spur   = 1'b0;
    spur_fit  = '0;
    fu_en     = 1'b1;
    ovr_en    = 1'b0;
    ovr_fit   = '0;
    fu_lat    = 3;

    vecs[0]  = '{4'b1111, 0, 1};
    vecs[1]  = '{4'b1111, 1, 2};
    vecs[2]  = '{4'b1111, 2, 3};
    vecs[3]  = '{4'b1111, 3, 4};
    vecs[4]  = '{4'b1111, 0, 1};
    vecs[5]  = '{4'b1111, 1, 2};
    vecs[6]  = '{4'b0001, 0, 3};
    vecs[7]  = '{4'b1010, 1, 4};
    vecs[8]  = '{4'b1010, 3, 1};
    vecs[9]  = '{4'b0110, 1, 2};
    vecs[10] = '{4'b1001, 3, 3};
    vecs[11] = '{4'b1001, 0, 4};
    vecs[12] = '{4'b1000, 3, 1};
    vecs[13] = '{4'b0100, 2, 2};

    fork
      monitor();
      begin
        stimulus();
        done = 1'b1;
      end
    join

    chk("queues_drained", 64'(gq.size() + rq.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
